// File: rtl/zx_video_pkg.sv
// Shared video definitions for the zx scandoubler and line buffer.
package zx_video_pkg;

   localparam int AW_DEFAULT  = 9;
   localparam int HSW_DEFAULT = 56;

   typedef struct packed {
      logic blank;
      logic i;
      logic r;
      logic g;
      logic b;
   } pixel_t;

   function automatic pixel_t make_pixel(input logic blank, input logic [3:0] color);
      pixel_t p;
      p = {blank, color};
      return p;
   endfunction

endpackage

// File: rtl/zx_linebuf.sv
// Ping-pong line store: one write port, one registered read port, single clock.
module zx_linebuf
   import zx_video_pkg::*;
#(
   parameter int AW = AW_DEFAULT
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW:0]   waddr,
   input  logic [4:0]    wdata,
   input  logic [AW:0]   raddr,
   output logic [4:0]    rdata
);

   logic [4:0] mem [0:(2**(AW+1))-1];

   // No reset on the array or read register so the store maps onto block RAM.
   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/zx_scandoubler.sv
// Captures each 15 kHz line into one buffer bank and replays the other bank
// twice at ce2x rate; with enable low the inputs are simply registered on ce1x.
module zx_scandoubler
   import zx_video_pkg::*;
#(
   parameter int AW  = AW_DEFAULT,
   parameter int HSW = HSW_DEFAULT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ce1x,
   input  logic       ce2x,
   input  logic       enable,
   input  logic       hsyncI,
   input  logic       vsyncI,
   input  logic       blankI,
   input  logic [3:0] colorI,
   output logic       hsyncO,
   output logic       vsyncO,
   output logic       blankO,
   output logic [3:0] colorO
);

   localparam logic [AW-1:0] HC_MAX = '1;
   localparam logic [AW-1:0] HC_ONE = AW'(1);
   localparam logic [AW-1:0] HSW_W  = AW'(HSW);

   logic [AW-1:0] hc_in;
   logic [AW-1:0] hc_out;
   logic [AW-1:0] line_len;
   logic          bank;
   logic          started;
   logic          valid;
   logic          hsync_prev;
   logic          en_q;

   logic          line_start;
   logic          we;
   logic [AW:0]   waddr;
   logic [AW:0]   raddr;
   logic [4:0]    rd_data;
   pixel_t        rd_pix;
   logic          rd_blank;
   logic          doubling;

   assign line_start = ce1x & hsync_prev & ~hsyncI;
   assign raddr      = {~bank, hc_out};
   assign rd_pix     = pixel_t'(rd_data);
   assign rd_blank   = rd_pix.blank | ~valid;
   // Mode changes only take hold on a ce1x sample.
   assign doubling   = ce1x ? enable : en_q;

   // The line-start pixel goes to address 0 of the bank about to become active.
   always_comb begin
      we    = 1'b0;
      waddr = {bank, hc_in};
      if (ce1x) begin
         if (line_start) begin
            we    = 1'b1;
            waddr = {~bank, {AW{1'b0}}};
         end else if (hc_in != HC_MAX) begin
            we    = 1'b1;
         end
      end
   end

   zx_linebuf #(.AW(AW)) u_linebuf (
      .clock (clock),
      .we    (we),
      .waddr (waddr),
      .wdata (make_pixel(blankI, colorI)),
      .raddr (raddr),
      .rdata (rd_data)
   );

   // hc_in counts pixels stored on the current line, so it equals the line
   // length at the next line start; it saturates to drop overlong tails.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hc_in      <= '0;
         line_len   <= '0;
         bank       <= 1'b0;
         started    <= 1'b0;
         valid      <= 1'b0;
         hsync_prev <= 1'b1;
      end else if (ce1x) begin
         hsync_prev <= hsyncI;
         if (line_start) begin
            line_len <= hc_in;
            hc_in    <= HC_ONE;
            bank     <= ~bank;
            started  <= 1'b1;
            // The bank exposed at the first line start holds a partial line.
            valid    <= started;
         end else if (hc_in != HC_MAX) begin
            hc_in    <= hc_in + HC_ONE;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hc_out <= '0;
      end else if (ce2x) begin
         if (line_start || line_len == '0) begin
            hc_out <= '0;
         end else if (hc_out == line_len - HC_ONE) begin
            hc_out <= '0;
         end else begin
            hc_out <= hc_out + HC_ONE;
         end
      end
   end

   // hc_out sampled here is the address whose data is arriving now, so the
   // registered hsync lines up with the registered colour.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         en_q   <= 1'b0;
         hsyncO <= 1'b1;
         vsyncO <= 1'b1;
         blankO <= 1'b1;
         colorO <= 4'h0;
      end else begin
         if (ce1x) begin
            en_q <= enable;
         end
         if (doubling) begin
            if (ce2x) begin
               hsyncO <= ~(hc_out < HSW_W);
               vsyncO <= vsyncI;
               blankO <= rd_blank;
               colorO <= rd_blank ? 4'h0 : {rd_pix.i, rd_pix.r, rd_pix.g, rd_pix.b};
            end
         end else if (ce1x) begin
            hsyncO <= hsyncI;
            vsyncO <= vsyncI;
            blankO <= blankI;
            colorO <= colorI;
         end
      end
   end

endmodule

// File: tb/tb_zx_scandoubler.sv
// Directed bench for zx_scandoubler: whole lines are driven and every ce2x
// output sample is compared against a replay model of the previous line.
module tb_zx_scandoubler;
   import zx_video_pkg::*;

   localparam int K_IDX   = 0;
   localparam int K_A     = 1;
   localparam int K_5     = 2;
   localparam int K_BLANK = 3;
   localparam int LMAX    = (1 << AW_DEFAULT) - 1;

   logic       clock = 1'b0;
   logic       reset;
   logic       ce1x;
   logic       ce2x;
   logic       enable;
   logic       hsyncI;
   logic       vsyncI;
   logic       blankI;
   logic [3:0] colorI;
   logic       hsyncO;
   logic       vsyncO;
   logic       blankO;
   logic [3:0] colorO;

   int n_checks = 0;
   int n_errors = 0;

   logic [6:0] smp[$];
   logic [6:0] exp_q[$];
   logic [6:0] msk_q[$];

   int prev_len  = 0;
   int prev_kind = 0;
   bit started_b = 0;

   typedef struct {
      logic       hs;
      logic       vs;
      logic       bl;
      logic [3:0] col;
      logic       ehs;
      logic       evs;
      logic       ebl;
      logic [3:0] ecol;
   } vec_t;

   vec_t tbl[10];

   zx_scandoubler dut (
      .clock  (clock),
      .reset  (reset),
      .ce1x   (ce1x),
      .ce2x   (ce2x),
      .enable (enable),
      .hsyncI (hsyncI),
      .vsyncI (vsyncI),
      .blankI (blankI),
      .colorI (colorI),
      .hsyncO (hsyncO),
      .vsyncO (vsyncO),
      .blankO (blankO),
      .colorO (colorO)
   );

   always #5 clock = ~clock;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [4:0] src_pix(input int kind, input int p);
      logic [4:0] s;
      case (kind)
         K_IDX:   s = {1'b0, 4'(p)};
         K_A:     s = {1'b0, 4'hA};
         K_5:     s = {1'b0, 4'h5};
         default: s = {(p < 96), 4'hF};
      endcase
      return s;
   endfunction

   // One input pixel: four clocks, ce1x+ce2x on the first, ce2x on the third.
   task automatic pix(input logic hs, input logic vs, input logic bl, input logic [3:0] col);
      hsyncI = hs;
      vsyncI = vs;
      blankI = bl;
      colorI = col;
      ce1x   = 1'b1;
      ce2x   = 1'b1;
      @(posedge clock);
      #1 smp.push_back({hsyncO, vsyncO, blankO, colorO});
      @(negedge clock);
      ce1x = 1'b0;
      ce2x = 1'b0;
      @(negedge clock);
      ce2x = 1'b1;
      @(posedge clock);
      #1 smp.push_back({hsyncO, vsyncO, blankO, colorO});
      @(negedge clock);
      ce2x = 1'b0;
      @(negedge clock);
   endtask

   task automatic compare_q(input string name);
      int bad;
      int first;
      bad   = 0;
      first = -1;
      for (int k = 0; k < exp_q.size(); k++) begin
         if ((smp[k] & msk_q[k]) !== (exp_q[k] & msk_q[k])) begin
            bad++;
            if (first < 0) first = k;
         end
      end
      if (bad != 0)
         check($sformatf("%s (first bad sample %0d got %h want %h, bad samples)", name, first,
                         smp[first] & msk_q[first], exp_q[first] & msk_q[first]), bad, 0);
      else
         check(name, bad, 0);
   endtask

   // Drive a full line (hsync low on pixels 0..31) and check the replay of
   // the previous line, or a blank screen before a complete line exists.
   task automatic send_line(input int len, input int kind, input int vs0, input int vlen,
                            input string name);
      bit valid_now;
      int eff;
      int nchk;
      logic [4:0] s;
      logic vs;
      int p;
      valid_now = started_b;
      eff       = (prev_len > LMAX) ? LMAX : prev_len;
      smp.delete();
      for (int i = 0; i < len; i++) begin
         s = src_pix(kind, i);
         pix((i < 32) ? 1'b0 : 1'b1, (vlen > 0 && i >= vs0 && i < vs0 + vlen) ? 1'b0 : 1'b1,
             s[4], s[3:0]);
      end
      nchk = 2 * len - 1;
      if (valid_now && 2 * eff < nchk) nchk = 2 * eff;
      exp_q.delete();
      msk_q.delete();
      for (int k = 0; k <= nchk; k++) begin
         vs = (vlen > 0 && k / 2 >= vs0 && k / 2 < vs0 + vlen) ? 1'b0 : 1'b1;
         if (k == 0) begin
            exp_q.push_back({1'b0, vs, 5'b0});
            msk_q.push_back(7'b0100000);
         end else if (valid_now) begin
            p = (k - 1) % eff;
            s = src_pix(prev_kind, p);
            exp_q.push_back({(p >= HSW_DEFAULT), vs, s[4], s[4] ? 4'h0 : s[3:0]});
            msk_q.push_back(7'b1111111);
         end else begin
            exp_q.push_back({1'b0, vs, 1'b1, 4'h0});
            msk_q.push_back(7'b0111111);
         end
      end
      compare_q(name);
      prev_len  = len;
      prev_kind = kind;
      started_b = 1'b1;
   endtask

   task automatic send_idle(input int n, input string name);
      smp.delete();
      exp_q.delete();
      msk_q.delete();
      for (int i = 0; i < n; i++) begin
         pix(1'b1, 1'b1, 1'b0, 4'h9);
         exp_q.push_back({1'b0, 1'b1, 1'b1, 4'h0});
         exp_q.push_back({1'b0, 1'b1, 1'b1, 4'h0});
         msk_q.push_back(7'b0111111);
         msk_q.push_back(7'b0111111);
      end
      compare_q(name);
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b1, 1'b0, 4'h7, 1'b1, 1'b1, 1'b0, 4'h7};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 4'h7, 1'b1, 1'b1, 1'b0, 4'h7};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 4'h7, 1'b0, 1'b1, 1'b0, 4'h7};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 4'h7};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 4'h7, 1'b1, 1'b0, 1'b0, 4'h7};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 1'b1, 1'b0, 4'h3};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 4'h7, 1'b1, 1'b1, 1'b0, 4'h7};
      tbl[7] = '{1'b0, 1'b1, 1'b0, 4'h7, 1'b0, 1'b1, 1'b0, 4'h7};
      tbl[8] = '{1'b1, 1'b1, 1'b0, 4'hC, 1'b1, 1'b1, 1'b0, 4'hC};
      tbl[9] = '{1'b1, 1'b1, 1'b0, 4'h7, 1'b1, 1'b1, 1'b0, 4'h7};

      // Clock/reset
      reset  = 1'b1;
      enable = 1'b1;
      ce1x   = 1'b0;
      ce2x   = 1'b0;
      hsyncI = 1'b1;
      vsyncI = 1'b1;
      blankI = 1'b0;
      colorI = 4'h0;
      @(negedge clock);
      @(negedge clock);
      check("reset hsyncO", hsyncO, 1'b1);
      check("reset vsyncO", vsyncO, 1'b1);
      check("reset blankO", blankO, 1'b1);
      check("reset colorO", colorO, 4'h0);
      reset = 1'b0;
      @(negedge clock);

      send_line(448, K_IDX,   0,   0, "first line blank");
      send_line(448, K_IDX,   0,   0, "steady replay 1");
      send_line(448, K_A,     0,   0, "steady replay 2");
      send_line(448, K_5,     0,   0, "bank swap shows A only");
      send_line(448, K_BLANK, 200, 3, "replay of 5 with vsync pulse");
      send_line(600, K_IDX,   0,   0, "blank pixels 0-95 replay");
      send_line(600, K_IDX,   0,   0, "overlong replay 511");
      send_line(448, K_IDX,   0,   0, "overlong second replay 511");

      // Asynchronous reset in the middle of a line
      smp.delete();
      for (int i = 0; i < 100; i++) pix((i < 32) ? 1'b0 : 1'b1, 1'b1, 1'b0, 4'(i));
      #2 reset = 1'b1;
      #1;
      check("mid-line reset hsyncO", hsyncO, 1'b1);
      check("mid-line reset vsyncO", vsyncO, 1'b1);
      check("mid-line reset blankO", blankO, 1'b1);
      check("mid-line reset colorO", colorO, 4'h0);
      @(negedge clock);
      @(negedge clock);
      reset     = 1'b0;
      started_b = 1'b0;
      prev_len  = 0;
      send_idle(20, "blank after reset");
      send_line(448, K_IDX, 0, 0, "blank until second line start");
      send_line(448, K_IDX, 0, 0, "replay after reset");

      // Bypass vectors
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         smp.delete();
         pix(tbl[i].hs, tbl[i].vs, tbl[i].bl, tbl[i].col);
         check($sformatf("bypass vec %0d", i), smp[0],
               {tbl[i].ehs, tbl[i].evs, tbl[i].ebl, tbl[i].ecol});
         check($sformatf("bypass hold %0d", i), smp[1],
               {tbl[i].ehs, tbl[i].evs, tbl[i].ebl, tbl[i].ecol});
      end
      check("line length tracked in bypass", dut.line_len, 5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
